// File: rtl/pipelined_stage_sequencer_pkg.sv
// Shared stage encodings and op-class constants for the five-stage control sequencer.
package pipelined_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd7
    } stage_e;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_BRANCH = 2'd3
    } op_class_e;

    function automatic logic uses_mem(op_class_e op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/pipelined_stage_sequencer_stage_wait_timer.sv
// Counts consecutive wait cycles; clears when not waiting, holds while frozen.
module stage_wait_timer #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_i,
    input  logic freeze_i,
    output logic terminal_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(MEM_TIMEOUT);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!freeze_i) cnt_d = count_i ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // A zero timeout disables the terminal compare entirely.
    assign terminal_o = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/pipelined_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller driving datapath enables.
module pipelined_stage_sequencer
    import pipelined_stage_sequencer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int SKIP_MEM    = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Op_Class,
    input  logic             Branch_Taken,
    input  logic             Mem_Ready,
    input  logic             Stall,
    output logic [2:0]       Stage,
    output logic             IR_Enable,
    output logic             PC_Enable,
    output logic             RA_Enable,
    output logic             RB_Enable,
    output logic             RZ_Enable,
    output logic             RM_Enable,
    output logic             RY_Enable,
    output logic             CCR_Enable,
    output logic             RF_WRITE,
    output logic             ROM1_Read,
    output logic             MEM_Request,
    output logic             MEM_Read_H_Write_L,
    output logic             Fault,
    output logic [CNT_W-1:0] Retired_Count
);

    stage_e           state_q, state_d;
    op_class_e        class_q, class_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             waiting, tmr_term, tmo_hit, skip_mem;

    assign skip_mem = (SKIP_MEM != 0) && !uses_mem(class_q);
    assign waiting  = !Mem_Ready && ((state_q == ST_FETCH) ||
                                     ((state_q == ST_MEMORY) && uses_mem(class_q)));
    assign tmo_hit  = waiting && tmr_term;

    stage_wait_timer #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .count_i    (waiting),
        .freeze_i   (Stall),
        .terminal_o (tmr_term)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            class_q   <= OP_ALU;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

    // Stall freezes everything except a faulted sequencer, which is frozen anyway.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        retired_d = retired_q;
        if (!Stall || state_q == ST_FAULT) begin
            case (state_q)
                ST_FETCH: begin
                    if (Mem_Ready)    state_d = ST_DECODE;
                    else if (tmo_hit) state_d = ST_FAULT;
                end
                ST_DECODE: begin
                    class_d = op_class_e'(Op_Class);
                    state_d = ST_EXECUTE;
                end
                ST_EXECUTE: state_d = skip_mem ? ST_WRITEBACK : ST_MEMORY;
                ST_MEMORY: begin
                    if (!uses_mem(class_q) || Mem_Ready) state_d = ST_WRITEBACK;
                    else if (tmo_hit)                    state_d = ST_FAULT;
                end
                ST_WRITEBACK: begin
                    retired_d = retired_q + 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        IR_Enable          = 1'b0;
        PC_Enable          = 1'b0;
        RA_Enable          = 1'b0;
        RB_Enable          = 1'b0;
        RZ_Enable          = 1'b0;
        RM_Enable          = 1'b0;
        RY_Enable          = 1'b0;
        CCR_Enable         = 1'b0;
        RF_WRITE           = 1'b0;
        ROM1_Read          = 1'b0;
        MEM_Request        = 1'b0;
        MEM_Read_H_Write_L = 1'b1;
        if (!Reset) begin
            if (state_q == ST_MEMORY && class_q == OP_STORE) MEM_Read_H_Write_L = 1'b0;
            if (!Stall) begin
                case (state_q)
                    ST_FETCH: begin
                        ROM1_Read = 1'b1;
                        IR_Enable = Mem_Ready;
                        PC_Enable = Mem_Ready;
                    end
                    ST_DECODE: begin
                        RA_Enable = 1'b1;
                        RB_Enable = 1'b1;
                    end
                    ST_EXECUTE: begin
                        RZ_Enable  = 1'b1;
                        CCR_Enable = (class_q == OP_ALU);
                        RM_Enable  = (class_q == OP_STORE);
                        PC_Enable  = (class_q == OP_BRANCH) && Branch_Taken;
                        RY_Enable  = skip_mem;
                    end
                    ST_MEMORY: begin
                        if (uses_mem(class_q)) begin
                            MEM_Request = 1'b1;
                            RY_Enable   = Mem_Ready && (class_q == OP_LOAD);
                        end else begin
                            RY_Enable   = 1'b1;
                        end
                    end
                    ST_WRITEBACK: RF_WRITE = (class_q == OP_ALU) || (class_q == OP_LOAD);
                    default: ;
                endcase
            end
        end
    end

    assign Stage         = state_q;
    assign Fault         = (state_q == ST_FAULT);
    assign Retired_Count = retired_q;

endmodule

// File: tb/tb_pipelined_stage_sequencer.sv
// Self-checking bench: literal vector table, per-instruction expected traces, random ops/stalls.
module tb_pipelined_stage_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Op_Class = 2'd0;
    logic        Branch_Taken = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic        Stall = 1'b0;
    logic [2:0]  Stage;
    logic        IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable;
    logic        CCR_Enable, RF_WRITE, ROM1_Read, MEM_Request, MEM_Read_H_Write_L, Fault;
    logic [15:0] Retired_Count;

    pipelined_stage_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Op_Class(Op_Class), .Branch_Taken(Branch_Taken),
        .Mem_Ready(Mem_Ready), .Stall(Stall), .Stage(Stage),
        .IR_Enable(IR_Enable), .PC_Enable(PC_Enable), .RA_Enable(RA_Enable),
        .RB_Enable(RB_Enable), .RZ_Enable(RZ_Enable), .RM_Enable(RM_Enable),
        .RY_Enable(RY_Enable), .CCR_Enable(CCR_Enable), .RF_WRITE(RF_WRITE),
        .ROM1_Read(ROM1_Read), .MEM_Request(MEM_Request),
        .MEM_Read_H_Write_L(MEM_Read_H_Write_L), .Fault(Fault), .Retired_Count(Retired_Count)
    );

    always #5 Clock = ~Clock;

    // Output word: [12]IR [11]PC [10]RA [9]RB [8]RZ [7]RM [6]RY [5]CCR [4]RFW [3]ROM [2]MREQ [1]RW [0]FLT
    typedef struct {
        logic [2:0]  stg;
        logic        mr, stall, bt;
        logic [1:0]  op;
        logic [12:0] outs;
        logic [15:0] cnt;
    } cyc_t;

    typedef struct {
        logic        mr;
        logic [1:0]  op;
        logic        bt;
        logic [2:0]  stg;
        logic [12:0] outs;
        logic [15:0] cnt;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mcnt = 16'd0;
    cyc_t        q[$];
    vec_t        vt[5];

    function automatic logic [12:0] act_outs();
        return {IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable,
                CCR_Enable, RF_WRITE, ROM1_Read, MEM_Request, MEM_Read_H_Write_L, Fault};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(logic [2:0] s, logic mr, logic [1:0] op, logic bt, logic [12:0] o);
        cyc_t c;
        c.stg = s; c.mr = mr; c.stall = 1'b0; c.bt = bt; c.op = op; c.outs = o; c.cnt = mcnt;
        return c;
    endfunction

    // Optionally precede a cycle with stalled copies: same stage, only the R/W level survives.
    task automatic push(input cyc_t c, input int nforce, input bit rnd);
        int n;
        cyc_t s;
        n = nforce + ((rnd && $urandom_range(0, 3) == 0) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            s = c;
            s.stall = 1'b1;
            s.mr = 1'($urandom); s.bt = 1'($urandom); s.op = 2'($urandom);
            s.outs = c.outs & 13'b0000000000010;
            q.push_back(s);
        end
        q.push_back(c);
    endtask

    // Expand one instruction into its expected cycle trace from the stage rules.
    task automatic add_instr(input logic [1:0] op, input int fw, input int mw, input logic bt,
                             input int nst_ex, input bit rnd);
        logic        isld, isst, ismem;
        logic [12:0] e;
        isld = (op == 2'd1); isst = (op == 2'd2); ismem = isld | isst;
        for (int k = 0; k < fw; k++)
            push(mk(3'd0, 1'b0, 2'($urandom), 1'($urandom), 13'b0000000001010), 0, rnd);
        push(mk(3'd0, 1'b1, 2'($urandom), 1'($urandom), 13'b1100000001010), 0, rnd);
        push(mk(3'd1, 1'($urandom), op, 1'($urandom), 13'b0011000000010), 0, rnd);
        e = 13'b0000100000010;
        e[11] = (op == 2'd3) && bt;
        e[7]  = isst;
        e[6]  = !ismem;
        e[5]  = (op == 2'd0);
        push(mk(3'd2, 1'($urandom), 2'($urandom), bt, e), nst_ex, rnd);
        if (ismem) begin
            e = 13'b0000000000100;
            e[1] = !isst;
            for (int k = 0; k < mw; k++)
                push(mk(3'd3, 1'b0, 2'($urandom), 1'($urandom), e), 0, rnd);
            e[6] = isld;
            push(mk(3'd3, 1'b1, 2'($urandom), 1'($urandom), e), 0, rnd);
        end
        e = 13'b0000000000010;
        e[4] = (op == 2'd0) || (op == 2'd1);
        push(mk(3'd4, 1'($urandom), 2'($urandom), 1'($urandom), e), 0, rnd);
        mcnt++;
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clock);
            Reset = 1'b0; Mem_Ready = c.mr; Stall = c.stall; Branch_Taken = c.bt; Op_Class = c.op;
            #2;
            chk("stage", 32'(Stage), 32'(c.stg));
            chk("outs", 32'(act_outs()), 32'(c.outs));
            chk("retired", 32'(Retired_Count), 32'(c.cnt));
        end
    endtask

    // Holds Reset for one edge; the following run_q cycle releases it.
    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; Stall = 1'b0; Mem_Ready = 1'b1; Op_Class = 2'd2; Branch_Taken = 1'b1;
        #2;
        chk("reset_outs", 32'(act_outs() & 13'b1111111111110), 32'(13'b0000000000010));
        mcnt = 16'd0;
    endtask

    initial begin
        vt[0] = '{mr: 1'b1, op: 2'd0, bt: 1'b0, stg: 3'd0, outs: 13'b1100000001010, cnt: 16'd0};
        vt[1] = '{mr: 1'b0, op: 2'd0, bt: 1'b0, stg: 3'd1, outs: 13'b0011000000010, cnt: 16'd0};
        vt[2] = '{mr: 1'b1, op: 2'd3, bt: 1'b1, stg: 3'd2, outs: 13'b0000101100010, cnt: 16'd0};
        vt[3] = '{mr: 1'b0, op: 2'd1, bt: 1'b0, stg: 3'd4, outs: 13'b0000000010010, cnt: 16'd0};
        vt[4] = '{mr: 1'b0, op: 2'd2, bt: 1'b0, stg: 3'd0, outs: 13'b0000000001010, cnt: 16'd1};

        do_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            Reset = 1'b0; Stall = 1'b0;
            Mem_Ready = vt[i].mr; Op_Class = vt[i].op; Branch_Taken = vt[i].bt;
            #2;
            chk("vec_stage", 32'(Stage), 32'(vt[i].stg));
            chk("vec_outs", 32'(act_outs()), 32'(vt[i].outs));
            chk("vec_retired", 32'(Retired_Count), 32'(vt[i].cnt));
        end

        // Directed instruction mix, including the last non-faulting fetch wait and an EXECUTE stall.
        do_reset();
        add_instr(2'd0, 0, 0, 1'b0, 0, 1'b0);
        add_instr(2'd1, 0, 3, 1'b0, 0, 1'b0);
        add_instr(2'd2, 1, 2, 1'b0, 0, 1'b0);
        add_instr(2'd3, 0, 0, 1'b1, 0, 1'b0);
        add_instr(2'd3, 2, 0, 1'b0, 0, 1'b0);
        add_instr(2'd0, 15, 0, 1'b0, 0, 1'b0);
        add_instr(2'd1, 0, 15, 1'b0, 0, 1'b0);
        add_instr(2'd0, 0, 0, 1'b0, 2, 1'b0);
        run_q();

        // Fetch timeout: 16 unanswered fetch cycles, then sticky FAULT regardless of Stall.
        do_reset();
        for (int k = 0; k < 16; k++)
            push(mk(3'd0, 1'b0, 2'($urandom), 1'($urandom), 13'b0000000001010), 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc_t c;
            c = mk(3'd7, 1'($urandom), 2'($urandom), 1'($urandom), 13'b0000000000011);
            c.stall = 1'($urandom);
            q.push_back(c);
        end
        run_q();

        // Reset lands while a STORE waits in MEMORY.
        do_reset();
        add_instr(2'd0, 0, 0, 1'b0, 0, 1'b0);
        add_instr(2'd2, 0, 6, 1'b0, 0, 1'b0);
        while (q.size() > 9) void'(q.pop_back());
        run_q();
        do_reset();
        add_instr(2'd0, 0, 0, 1'b0, 0, 1'b0);
        run_q();

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 60; n++)
            add_instr(2'($urandom), ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 5)), 1'($urandom), 0, 1'b1);
        run_q();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
